tdm_mux_demux: RTL and testbench
================================

Name: tdm_mux_demux

Overview:
- Parametrised N-channel successor to the 2:1 gate-level mux/demux pair.
- Mux side: selects one of CHANNELS input words into a registered tagged bus, with a valid/ready handshake, in either fixed-select or round-robin mode.
- Demux side: takes a tagged bus word and writes it into the addressed per-channel output register, with a one-cycle strobe.
- Used as the time-division link between multi-channel datapaths in the lab designs.

Parameters:
- WIDTH, 8, data word width in bits.
- CHANNELS, 4, number of channels (2..16).
- SEL_W, 2, channel index width; must satisfy 2**SEL_W >= CHANNELS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select by sel; 1 = round-robin scan.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  CHANNELS*WIDTH  packed input words; channel k occupies [k*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel word-available flags.
- in_ack  output  CHANNELS  one-hot, combinational; high in the cycle the channel's word is loaded.
- bus_data  output  WIDTH  registered bus word.
- bus_ch  output  SEL_W  registered channel tag of bus_data.
- bus_valid  output  1  registered; bus word is valid.
- bus_ready  input  1  downstream accepts the bus word this cycle.
- rx_data  input  WIDTH  incoming tagged word for the demux.
- rx_ch  input  SEL_W  channel tag of rx_data.
- rx_valid  input  1  rx word present this cycle.
- out_data  output  CHANNELS*WIDTH  registered per-channel demux outputs.
- out_strobe  output  CHANNELS  registered one-hot; one-cycle pulse on the channel just written.
- drop_cnt  output  8  saturating count of rx words with rx_ch >= CHANNELS.

Behaviour:
- Reset (rst_n=0, asynchronous): bus_data=0, bus_ch=0, bus_valid=0, rr_ptr=0, out_data=0, out_strobe=0, drop_cnt=0. in_ack=0 while rst_n=0.
- Reset mid-transfer discards the bus word. There is no replay.
- can_load = !bus_valid || bus_ready.
- Mode 0 load condition: can_load && sel<CHANNELS && in_valid[sel].
  - Winner = sel.
  - sel >= CHANNELS never loads and never asserts in_ack.
- Mode 1 winner: first k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, ... modulo CHANNELS (wrap-around).
  - On load, rr_ptr <= (winner+1) mod CHANNELS.
  - No valid channel, or no load: rr_ptr holds.
- On load:
  - bus_data <= in_data[winner], bus_ch <= winner, bus_valid <= 1.
  - in_ack[winner]=1 in the same cycle.
- bus_valid && bus_ready with no new load: bus_valid <= 0. bus_data and bus_ch hold their last values.
- Accept and reload in the same cycle is allowed: sustained 1 word per cycle.
- Stall: bus_valid && !bus_ready.
  - bus_data, bus_ch and bus_valid hold.
  - in_ack all 0; rr_ptr holds.
- Latency: in_valid to bus_valid is 1 cycle.
- Mode or sel changes take effect in the cycle they are sampled. rr_ptr is not cleared on a mode change.
- Demux, rx_valid && rx_ch<CHANNELS: out_data[rx_ch] <= rx_data, out_strobe <= one-hot(rx_ch). Other channels hold.
- Demux, rx_valid && rx_ch>=CHANNELS: word dropped; out_strobe <= 0; drop_cnt <= min(drop_cnt+1, 255).
- Demux, rx_valid=0: out_strobe <= 0.
- Demux latency: 1 cycle. The demux is independent of the mux side and has no backpressure.

Test Plan:
1. Fixed select, CHANNELS=4, WIDTH=8: mode=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, bus_ready=1 -> in_ack=4'b0100; next cycle bus_data=A5, bus_ch=2, bus_valid=1. Then sel=1 with in_valid[1]=0 -> no load; bus_valid falls after accept.
2. Round-robin fairness: mode=1, in_valid=4'b1111, bus_ready=1 for 5 cycles -> bus_ch sequence 0,1,2,3,0.
   - Then in_valid=4'b1010 starting from rr_ptr=1 -> bus_ch sequence 1,3,1.
3. Backpressure: load ch0=8'h11, bus_ready=0 for 3 cycles -> bus_data=11 and bus_valid=1 held, in_ack=0, rr_ptr unchanged. bus_ready=1 with ch1 valid -> same-cycle accept and reload; bus_ch=1 next cycle.
4. Demux: rx_valid=1, rx_ch=3, rx_data=8'h3C -> next cycle out_data[31:24]=3C, out_strobe=4'b1000; other channels unchanged; the strobe is low the following cycle.
5. Drop/saturation: CHANNELS=3, SEL_W=2, rx_ch=3 with rx_valid=1 for 260 cycles -> drop_cnt=255, out_strobe stays 0, out_data unchanged.
6. Async reset mid-operation: with bus_valid=1 and drop_cnt=7, pulse rst_n low between clock edges -> all outputs 0 immediately. After release, mode=1 with in_valid=4'b1111 -> first bus_ch=0.

Source files
------------

// File: rtl/tdm_mux_demux.sv
// tdm_mux_demux: N-channel time-division link.
// Mux side: picks one channel word (fixed select or round-robin) into a
// registered tagged bus with a valid/ready handshake.
// Demux side: steers a tagged rx word into its per-channel output register
// with a one-cycle strobe, counting words whose tag has no channel.
module tdm_mux_demux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            sel,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    input  logic [CHANNELS-1:0]         in_valid,
    output logic [CHANNELS-1:0]         in_ack,
    output logic [WIDTH-1:0]            bus_data,
    output logic [SEL_W-1:0]            bus_ch,
    output logic                        bus_valid,
    input  logic                        bus_ready,
    input  logic [WIDTH-1:0]            rx_data,
    input  logic [SEL_W-1:0]            rx_ch,
    input  logic                        rx_valid,
    output logic [CHANNELS*WIDTH-1:0]   out_data,
    output logic [CHANNELS-1:0]         out_strobe,
    output logic [7:0]                  drop_cnt
);

    logic [WIDTH-1:0]          bus_data_q,   bus_data_d;
    logic [SEL_W-1:0]          bus_ch_q,     bus_ch_d;
    logic                      bus_valid_q,  bus_valid_d;
    logic [SEL_W-1:0]          rr_ptr_q,     rr_ptr_d;
    logic [CHANNELS*WIDTH-1:0] out_data_q,   out_data_d;
    logic [CHANNELS-1:0]       out_strobe_q, out_strobe_d;
    logic [7:0]                drop_cnt_q,   drop_cnt_d;

    logic                      can_load;
    logic                      found;
    logic                      load;
    logic [SEL_W-1:0]          win;
    logic [WIDTH-1:0]          win_data;
    logic                      rx_hit;

    // Saturating 8-bit increment for the drop counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Arbitration: find the winning channel for this cycle (fixed or round-robin).
    always_comb begin
        int idx;
        found    = 1'b0;
        win      = '0;
        win_data = '0;
        idx      = 0;
        if (!mode) begin
            // An out-of-range sel matches no k, so it never loads.
            for (int k = 0; k < CHANNELS; k++) begin
                if (int'(sel) == k && in_valid[k]) begin
                    found    = 1'b1;
                    win      = SEL_W'(k);
                    win_data = in_data[k*WIDTH +: WIDTH];
                end
            end
        end else begin
            // Scan starting at rr_ptr with wrap-around; first hit wins.
            for (int i = 0; i < CHANNELS; i++) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (!found && in_valid[idx]) begin
                    found    = 1'b1;
                    win      = SEL_W'(idx);
                    win_data = in_data[idx*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Handshake and bus next-state: load, accept-only, or stall.
    always_comb begin
        int nxt;
        can_load    = !bus_valid_q || bus_ready;
        // Gating with rst_n keeps in_ack low while reset is held.
        load        = rst_n && can_load && found;
        bus_data_d  = bus_data_q;
        bus_ch_d    = bus_ch_q;
        bus_valid_d = bus_valid_q;
        rr_ptr_d    = rr_ptr_q;
        nxt         = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            in_ack[k] = load && (int'(win) == k);
        end
        if (load) begin
            bus_data_d  = win_data;
            bus_ch_d    = win;
            bus_valid_d = 1'b1;
            if (mode) begin
                nxt = int'(win) + 1;
                if (nxt >= CHANNELS) nxt = 0;
                rr_ptr_d = SEL_W'(nxt);
            end
        end else if (bus_ready) begin
            bus_valid_d = 1'b0;
        end
    end

    // Demux next-state: write the addressed channel or count a drop.
    always_comb begin
        out_data_d   = out_data_q;
        out_strobe_d = '0;
        drop_cnt_d   = drop_cnt_q;
        rx_hit       = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (rx_valid && int'(rx_ch) == k) begin
                rx_hit                       = 1'b1;
                out_data_d[k*WIDTH +: WIDTH] = rx_data;
                out_strobe_d[k]              = 1'b1;
            end
        end
        if (rx_valid && !rx_hit) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_data_q   <= '0;
            bus_ch_q     <= '0;
            bus_valid_q  <= 1'b0;
            rr_ptr_q     <= '0;
            out_data_q   <= '0;
            out_strobe_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            bus_data_q   <= bus_data_d;
            bus_ch_q     <= bus_ch_d;
            bus_valid_q  <= bus_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            out_data_q   <= out_data_d;
            out_strobe_q <= out_strobe_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign bus_data   = bus_data_q;
    assign bus_ch     = bus_ch_q;
    assign bus_valid  = bus_valid_q;
    assign out_data   = out_data_q;
    assign out_strobe = out_strobe_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_tdm_mux_demux.sv
// Testbench for tdm_mux_demux: table-driven mux vectors on a 4-channel
// instance, hand-written demux, drop/saturation and async-reset sequences
// on a 4-channel and a 3-channel instance.
module tb_tdm_mux_demux;

    logic        clk;
    logic        rst_n;

    // 4-channel instance signals
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ack;
    logic [7:0]  bus_data;
    logic [1:0]  bus_ch;
    logic        bus_valid;
    logic        bus_ready;
    logic [7:0]  rx_data;
    logic [1:0]  rx_ch;
    logic        rx_valid;
    logic [31:0] out_data;
    logic [3:0]  out_strobe;
    logic [7:0]  drop_cnt;

    // 3-channel instance signals
    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ack3;
    logic [7:0]  bus_data3;
    logic [1:0]  bus_ch3;
    logic        bus_valid3;
    logic        bus_ready3;
    logic [7:0]  rx_data3;
    logic [1:0]  rx_ch3;
    logic        rx_valid3;
    logic [23:0] out_data3;
    logic [2:0]  out_strobe3;
    logic [7:0]  drop_cnt3;

    int total;
    int bad;

    tdm_mux_demux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
        .bus_data(bus_data), .bus_ch(bus_ch), .bus_valid(bus_valid),
        .bus_ready(bus_ready), .rx_data(rx_data), .rx_ch(rx_ch),
        .rx_valid(rx_valid), .out_data(out_data), .out_strobe(out_strobe),
        .drop_cnt(drop_cnt)
    );

    tdm_mux_demux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ack(in_ack3),
        .bus_data(bus_data3), .bus_ch(bus_ch3), .bus_valid(bus_valid3),
        .bus_ready(bus_ready3), .rx_data(rx_data3), .rx_ch(rx_ch3),
        .rx_valid(rx_valid3), .out_data(out_data3), .out_strobe(out_strobe3),
        .drop_cnt(drop_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] vld;
        logic       rdy;
        logic [3:0] ack;
        logic       bv;
        logic [1:0] ch;
        logic [7:0] dat;
    } vec_t;

    vec_t vecs[19];

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        mode = 1'b1; sel = 2'd0; in_valid = 4'b1111; bus_ready = 1'b1;
        in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        rx_data = 8'h00; rx_ch = 2'd0; rx_valid = 1'b0;
        mode3 = 1'b0; sel3 = 2'd0; in_data3 = {8'h33, 8'h22, 8'h11};
        in_valid3 = 3'b000; bus_ready3 = 1'b1;
        rx_data3 = 8'h00; rx_ch3 = 2'd0; rx_valid3 = 1'b0;

        //                mode  sel   vld      rdy   ack      bv    ch    dat
        vecs[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
        vecs[1]  = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA5};
        vecs[2]  = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 8'h44};
        vecs[3]  = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h44};
        vecs[4]  = '{1'b0, 2'd3, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h44};
        vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
        vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
        vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
        vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
        vecs[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
        vecs[10] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
        vecs[11] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
        vecs[12] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
        vecs[13] = '{1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
        vecs[14] = '{1'b1, 2'd0, 4'b0011, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h11};
        vecs[15] = '{1'b1, 2'd0, 4'b0011, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h11};
        vecs[16] = '{1'b1, 2'd0, 4'b0011, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h11};
        vecs[17] = '{1'b1, 2'd0, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
        vecs[18] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h22};

        // Reset state
        #2;
        chk("rst in_ack", 64'(in_ack), 64'h0);
        chk("rst bus_valid", 64'(bus_valid), 64'h0);
        chk("rst bus_data", 64'(bus_data), 64'h0);
        chk("rst bus_ch", 64'(bus_ch), 64'h0);
        chk("rst out_data", 64'(out_data), 64'h0);
        chk("rst out_strobe", 64'(out_strobe), 64'h0);
        chk("rst drop_cnt", 64'(drop_cnt), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 4'b0000;

        // Mux vectors
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            mode = vecs[i].mode; sel = vecs[i].sel;
            in_valid = vecs[i].vld; bus_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d in_ack", i), 64'(in_ack), 64'(vecs[i].ack));
            @(posedge clk); #1;
            chk($sformatf("vec%0d bus_valid", i), 64'(bus_valid), 64'(vecs[i].bv));
            chk($sformatf("vec%0d bus_ch", i), 64'(bus_ch), 64'(vecs[i].ch));
            chk($sformatf("vec%0d bus_data", i), 64'(bus_data), 64'(vecs[i].dat));
        end

        // Demux write to ch3, strobe falls next cycle
        @(negedge clk);
        rx_valid = 1'b1; rx_ch = 2'd3; rx_data = 8'h3C;
        @(posedge clk); #1;
        chk("dmx ch3 data", 64'(out_data), 64'h3C00_0000);
        chk("dmx ch3 strobe", 64'(out_strobe), 64'h8);
        @(negedge clk);
        rx_valid = 1'b0;
        @(posedge clk); #1;
        chk("dmx idle strobe", 64'(out_strobe), 64'h0);
        chk("dmx idle data", 64'(out_data), 64'h3C00_0000);
        @(negedge clk);
        rx_valid = 1'b1; rx_ch = 2'd0; rx_data = 8'h5A;
        @(posedge clk); #1;
        chk("dmx ch0 data", 64'(out_data), 64'h3C00_005A);
        chk("dmx ch0 strobe", 64'(out_strobe), 64'h1);
        chk("dmx no drops", 64'(drop_cnt), 64'h0);
        @(negedge clk);
        rx_valid = 1'b0;

        // Out-of-range sel on the 3-channel instance never loads
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
        #1;
        chk("sel oob in_ack", 64'(in_ack3), 64'h0);
        @(posedge clk); #1;
        chk("sel oob bus_valid", 64'(bus_valid3), 64'h0);
        @(negedge clk);
        in_valid3 = 3'b000;

        // Seven drops on the 3-channel instance
        rx_valid3 = 1'b1; rx_ch3 = 2'd3; rx_data3 = 8'hEE;
        repeat (7) @(posedge clk);
        #1;
        chk("drop cnt 7", 64'(drop_cnt3), 64'd7);
        chk("drop strobe", 64'(out_strobe3), 64'h0);
        @(negedge clk);
        rx_valid3 = 1'b0;

        // Hold a word on the bus, then reset between edges
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; bus_ready = 1'b0;
        @(posedge clk); #1;
        chk("pre-rst bus_valid", 64'(bus_valid), 64'h1);
        @(negedge clk);
        mode = 1'b1; in_valid = 4'b1111; bus_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst bus_valid", 64'(bus_valid), 64'h0);
        chk("arst bus_data", 64'(bus_data), 64'h0);
        chk("arst bus_ch", 64'(bus_ch), 64'h0);
        chk("arst in_ack", 64'(in_ack), 64'h0);
        chk("arst out_data", 64'(out_data), 64'h0);
        chk("arst drop_cnt3", 64'(drop_cnt3), 64'h0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post-rst in_ack", 64'(in_ack), 64'h1);
        @(posedge clk); #1;
        chk("post-rst bus_ch", 64'(bus_ch), 64'h0);
        chk("post-rst bus_valid", 64'(bus_valid), 64'h1);
        chk("post-rst bus_data", 64'(bus_data), 64'h11);
        @(negedge clk);
        in_valid = 4'b0000;

        // Saturation: write ch1, then 260 dropped words
        rx_valid3 = 1'b1; rx_ch3 = 2'd1; rx_data3 = 8'h77;
        @(posedge clk); #1;
        chk("sat ch1 strobe", 64'(out_strobe3), 64'h2);
        @(negedge clk);
        rx_ch3 = 2'd3; rx_data3 = 8'h99;
        repeat (260) @(posedge clk);
        #1;
        chk("sat drop_cnt", 64'(drop_cnt3), 64'd255);
        chk("sat strobe", 64'(out_strobe3), 64'h0);
        chk("sat out_data", 64'(out_data3), 64'h00_7700);
        @(negedge clk);
        rx_valid3 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
